// File: rtl/bit_frame_deserializer.sv
// bit_frame_deserializer
// Samples the raw serial line on each rising edge of the recovered bit clock,
// hunts for the sync word, then emits aligned DATA_W-bit words. A watchdog,
// scaled by the measured half-period, drops lock when the bit clock stalls.
//
// Ports:
//   clk        global clock (sole clock)
//   rst        asynchronous active-high reset
//   signal     raw serial line (asynchronous, synchronized here)
//   clk_rec    recovered bit clock, already in the clk domain
//   clk_freq   half-period count from clock recovery, 0 = unknown
//   hunt       one-cycle pulse forcing re-alignment
//   data_out   last completed word
//   data_valid one-cycle pulse, data_out updated this cycle
//   locked     high while aligned
//   clk_lost   sticky watchdog flag, cleared by the next sample strobe
`timescale 1ns/1ps

module bit_frame_deserializer #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = 8'hA5,
    parameter int unsigned       CLK_LEN   = 16,
    parameter int unsigned       WD_SHIFT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signal,
    input  logic               clk_rec,
    input  logic [CLK_LEN-1:0] clk_freq,
    input  logic               hunt,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               locked,
    output logic               clk_lost
);

    localparam int unsigned FILL_W = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned WD_W   = CLK_LEN + WD_SHIFT;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state, state_n;
    logic                sig_m, sig_s;
    logic                rec_d;
    logic [DATA_W-1:0]   sh, sh_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [WD_W-1:0]     wd, wd_n;
    logic [DATA_W-1:0]   data_out_n;
    logic                data_valid_n;
    logic                locked_n;
    logic                clk_lost_n;

    logic                strobe;
    logic [DATA_W-1:0]   sh_shift;
    logic [WD_W-1:0]     wd_limit;
    logic                wd_trip;

    // Input synchronizer and recovered-clock edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_m <= 1'b0;
            sig_s <= 1'b0;
            rec_d <= 1'b0;
        end else begin
            sig_m <= signal;
            sig_s <= sig_m;
            rec_d <= clk_rec;
        end
    end

    assign strobe   = clk_rec & ~rec_d;
    assign sh_shift = {sh[DATA_W-2:0], sig_s};
    assign wd_limit = WD_W'(clk_freq) << WD_SHIFT;

    // Trip once per stall: clk_lost blocks re-trips until a strobe clears it,
    // and a strobe in the same cycle always wins.
    assign wd_trip = (clk_freq != '0) && !strobe && !clk_lost && (wd == wd_limit);

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            sh         <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            wd         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            clk_lost   <= 1'b0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            fill       <= fill_n;
            bit_cnt    <= bit_cnt_n;
            wd         <= wd_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            locked     <= locked_n;
            clk_lost   <= clk_lost_n;
        end
    end

    // Next-state, alignment, word assembly and watchdog
    always_comb begin
        state_n      = state;
        sh_n         = sh;
        fill_n       = fill;
        bit_cnt_n    = bit_cnt;
        wd_n         = wd;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        clk_lost_n   = clk_lost;

        if (strobe) begin
            wd_n       = '0;
            clk_lost_n = 1'b0;
        end else if (wd != '1) begin
            wd_n = wd + WD_W'(1);
        end

        if (wd_trip) begin
            clk_lost_n = 1'b1;
            state_n    = ST_HUNT;
            sh_n       = '0;
            fill_n     = '0;
            bit_cnt_n  = '0;
        end

        if (hunt) begin
            // Hunt overrides any coincident strobe; that bit is dropped.
            state_n   = ST_HUNT;
            sh_n      = '0;
            fill_n    = '0;
            bit_cnt_n = '0;
        end else if (strobe) begin
            sh_n = sh_shift;
            case (state)
                ST_HUNT: begin
                    fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
                    if ((fill_n == FILL_FULL) && (sh_shift == SYNC_WORD)) begin
                        state_n   = ST_LOCKED;
                        bit_cnt_n = '0;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt == CNT_LAST) begin
                        data_out_n   = sh_shift;
                        data_valid_n = 1'b1;
                        bit_cnt_n    = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end

        locked_n = (state_n == ST_LOCKED);
    end

endmodule

// File: tb/tb_bit_frame_deserializer.sv
// Directed bench for bit_frame_deserializer: expected words are queued as
// they are driven and compared as data_valid pulses appear.
`timescale 1ns/1ps

module tb_bit_frame_deserializer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CLK_LEN = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               signal;
    logic               clk_rec;
    logic [CLK_LEN-1:0] clk_freq;
    logic               hunt;
    logic [DATA_W-1:0]  data_out;
    logic               data_valid;
    logic               locked;
    logic               clk_lost;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    bit_frame_deserializer #(
        .DATA_W   (DATA_W),
        .SYNC_WORD(8'hA5),
        .CLK_LEN  (CLK_LEN),
        .WD_SHIFT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .signal    (signal),
        .clk_rec   (clk_rec),
        .clk_freq  (clk_freq),
        .hunt      (hunt),
        .data_out  (data_out),
        .data_valid(data_valid),
        .locked    (locked),
        .clk_lost  (clk_lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One bit per 20 cycles; the strobe edge is the 11th tick, 9 ticks remain after it.
    task automatic send_bit(input logic b);
        signal = b;
        repeat (10) tick();
        clk_rec = 1'b1;
        tick();
        repeat (9) tick();
        clk_rec = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Scoreboard: every valid pulse must match the oldest queued word.
    always @(posedge clk) begin
        logic have;
        logic [DATA_W-1:0] e;
        #1;
        if (data_valid) begin
            have = (exp_q.size() > 0);
            total++;
            assert (have === 1'b1) else begin
                bad++;
                $error("FAIL unexpected_valid: observed=%0h expected=none", data_out);
            end
            if (have) begin
                e = exp_q.pop_front();
                total++;
                assert (data_out === e) else begin
                    bad++;
                    $error("FAIL data_word: observed=%0h expected=%0h", data_out, e);
                end
            end
        end
    end

    initial begin
        logic [7:0] w;
        logic seen_lost;

        rst      = 1'b1;
        signal   = 1'b0;
        clk_rec  = 1'b0;
        clk_freq = '0;
        hunt     = 1'b0;
        repeat (3) tick();
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_clk_lost", 32'(clk_lost), 32'h0);
        rst = 1'b0;
        tick();

        // 1: sync word then three data words
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("t1_prelock", 32'(locked), 32'h0);
        send_bit(w[0]);
        chk("t1_lock", 32'(locked), 32'h1);
        exp_q.push_back(8'h3C); send_word(8'h3C);
        chk("t1_q_3c", 32'(exp_q.size()), 32'h0);
        exp_q.push_back(8'h00); send_word(8'h00);
        chk("t1_q_00", 32'(exp_q.size()), 32'h0);
        exp_q.push_back(8'hFF); send_word(8'hFF);
        chk("t1_q_ff", 32'(exp_q.size()), 32'h0);

        // 2: noise prefix, lock only at completion of the sync word
        hunt = 1'b1; tick(); hunt = 1'b0; tick();
        chk("t2_unlock", 32'(locked), 32'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("t2_prelock", 32'(locked), 32'h0);
        send_bit(w[0]);
        chk("t2_lock", 32'(locked), 32'h1);
        exp_q.push_back(8'h5A); send_word(8'h5A);
        chk("t2_q_5a", 32'(exp_q.size()), 32'h0);

        // 3: watchdog at clk_freq=10 trips 41 edges after the last strobe edge
        clk_freq = 16'd10;
        exp_q.push_back(8'hC3); send_word(8'hC3);
        chk("t3_q_c3", 32'(exp_q.size()), 32'h0);
        repeat (31) tick();
        chk("t3_pre_lost", 32'(clk_lost), 32'h0);
        chk("t3_pre_locked", 32'(locked), 32'h1);
        tick();
        chk("t3_lost", 32'(clk_lost), 32'h1);
        chk("t3_unlocked", 32'(locked), 32'h0);
        repeat (100) tick();
        chk("t3_sticky", 32'(clk_lost), 32'h1);
        send_bit(1'b1);
        chk("t3_cleared", 32'(clk_lost), 32'h0);
        clk_freq = '0;

        // 4: hunt coincident with a strobe mid-word
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        chk("t4_lock", 32'(locked), 32'h1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        signal = 1'b1;
        repeat (10) tick();
        clk_rec = 1'b1;
        hunt    = 1'b1;
        tick();
        hunt = 1'b0;
        repeat (9) tick();
        clk_rec = 1'b0;
        chk("t4_hunt_unlock", 32'(locked), 32'h0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_word(8'h12);
        chk("t4_no_lock", 32'(locked), 32'h0);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("t4_prelock", 32'(locked), 32'h0);
        send_bit(w[0]);
        chk("t4_relock", 32'(locked), 32'h1);
        exp_q.push_back(8'h77); send_word(8'h77);
        chk("t4_q_77", 32'(exp_q.size()), 32'h0);

        // 5: reset after 5 bits of a word
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("t5_before_rst", 32'(data_out), 32'h77);
        rst = 1'b1;
        #1;
        chk("t5_rst_data", 32'(data_out), 32'h0);
        chk("t5_rst_valid", 32'(data_valid), 32'h0);
        chk("t5_rst_locked", 32'(locked), 32'h0);
        chk("t5_rst_lost", 32'(clk_lost), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        chk("t5_no_lock", 32'(locked), 32'h0);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("t5_prelock", 32'(locked), 32'h0);
        send_bit(w[0]);
        chk("t5_relock", 32'(locked), 32'h1);
        exp_q.push_back(8'hE1); send_word(8'hE1);
        chk("t5_q_e1", 32'(exp_q.size()), 32'h0);

        // 6: unknown period disables the watchdog
        clk_freq  = '0;
        seen_lost = 1'b0;
        repeat (70000) begin
            tick();
            if (clk_lost) seen_lost = 1'b1;
        end
        chk("t6_no_lost", 32'(seen_lost), 32'h0);
        chk("t6_locked", 32'(locked), 32'h1);

        chk("final_queue", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
